// File: rtl/fdivsqrt_seq_fsm.sv
// fdivsqrt_seq_fsm: start/busy/done sequencer for the divide/sqrt digit-recurrence loop.
module fdivsqrt_seq_fsm #(
    parameter int CYCW      = 6,
    parameter bit EARLYTERM = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FDivStartE,
    input  logic            IDivStartE,
    input  logic            SpecialCaseE,
    input  logic [CYCW-1:0] CyclesE,
    input  logic            WZeroE,
    input  logic            FlushE,
    input  logic            StallM,
    output logic            IFDivStartE,
    output logic            IterEnE,
    output logic            FDivBusyE,
    output logic            FDivDoneE,
    output logic [CYCW-1:0] StepCntE
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t          state_q;
    logic [CYCW-1:0] cnt_q;
    logic            start;
    logic            idle, busy, done;
    // Gating with reset keeps every output low while reset is held, even with a start pending.
    assign start       = (FDivStartE | IDivStartE) & ~FlushE & reset;
    assign idle        = state_q == IDLE;
    assign busy        = state_q == BUSY;
    assign done        = state_q == DONE;
    assign IFDivStartE = idle & start;
    assign IterEnE     = busy;
    assign FDivDoneE   = done;
    assign FDivBusyE   = busy | (idle & start & ~SpecialCaseE) | (done & StallM);
    assign StepCntE    = cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= SpecialCaseE ? DONE : BUSY;
                    if (!SpecialCaseE) cnt_q <= (CyclesE == '0) ? CYCW'(1) : CyclesE;
                end
                BUSY: if (FlushE) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end else if (cnt_q == CYCW'(1) || (EARLYTERM && WZeroE)) begin
                    state_q <= DONE;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= (cnt_q == '0) ? '0 : cnt_q - CYCW'(1);
                end
                DONE: if (FlushE || !StallM) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fdivsqrt_seq_fsm.sv
// tb_fdivsqrt_seq_fsm: directed bench for the divide/sqrt sequencer (EARLYTERM=1 and 0 instances).
module tb_fdivsqrt_seq_fsm;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       FDivStartE = 1'b0, IDivStartE = 1'b0, SpecialCaseE = 1'b0;
    logic [5:0] CyclesE = '0;
    logic       WZeroE = 1'b0, FlushE = 1'b0, StallM = 1'b0;
    logic       ifs1, it1, bz1, dn1, ifs0, it0, bz0, dn0;
    logic [5:0] cnt1, cnt0;
    int         tests = 0, fails = 0;

    always #5 clk = ~clk;

    fdivsqrt_seq_fsm #(.CYCW(6), .EARLYTERM(1'b1)) u1 (
        .clk(clk), .reset(reset), .FDivStartE(FDivStartE), .IDivStartE(IDivStartE),
        .SpecialCaseE(SpecialCaseE), .CyclesE(CyclesE), .WZeroE(WZeroE), .FlushE(FlushE),
        .StallM(StallM), .IFDivStartE(ifs1), .IterEnE(it1), .FDivBusyE(bz1),
        .FDivDoneE(dn1), .StepCntE(cnt1)
    );
    fdivsqrt_seq_fsm #(.CYCW(6), .EARLYTERM(1'b0)) u0 (
        .clk(clk), .reset(reset), .FDivStartE(FDivStartE), .IDivStartE(IDivStartE),
        .SpecialCaseE(SpecialCaseE), .CyclesE(CyclesE), .WZeroE(WZeroE), .FlushE(FlushE),
        .StallM(StallM), .IFDivStartE(ifs0), .IterEnE(it0), .FDivBusyE(bz0),
        .FDivDoneE(dn0), .StepCntE(cnt0)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1(input string tag);
        chk({tag, "_it"}, int'(it1), 0);
        chk({tag, "_bz"}, int'(bz1), 0);
        chk({tag, "_dn"}, int'(dn1), 0);
    endtask

    initial begin
        // Reset held with a pending start: all outputs must stay low.
        FDivStartE = 1'b1;
        #2;
        chk("rst_ifs", int'(ifs1), 0);
        chk("rst_bz", int'(bz1), 0);
        chk("rst_cnt", int'(cnt1), 0);
        idle1("rst");
        FDivStartE = 1'b0;
        #10 reset = 1'b1;
        tick();
        // Flushed start is no start.
        FDivStartE = 1'b1; FlushE = 1'b1; #1;
        chk("flst_ifs", int'(ifs1), 0);
        chk("flst_bz", int'(bz1), 0);
        tick();
        FlushE = 1'b0; FDivStartE = 1'b0; #1;
        idle1("flst");
        // Normal op, CyclesE=5; CyclesE changed afterwards must be ignored.
        FDivStartE = 1'b1; CyclesE = 6'd5; #1;
        chk("n_ifs", int'(ifs1), 1);
        chk("n_bz0", int'(bz1), 1);
        chk("n_it0", int'(it1), 0);
        tick();
        FDivStartE = 1'b0; CyclesE = 6'd9;
        for (int i = 0; i < 5; i++) begin
            chk("n_it", int'(it1), 1);
            chk("n_cnt", int'(cnt1), 5 - i);
            chk("n_dn", int'(dn1), 0);
            chk("n_ifsb", int'(ifs1), 0);
            tick();
        end
        chk("n_done", int'(dn1), 1);
        chk("n_dbz", int'(bz1), 0);
        chk("n_dit", int'(it1), 0);
        chk("n_dcnt", int'(cnt1), 0);
        tick();
        idle1("n_end");
        // Special case: done next cycle, never busy, no iteration.
        IDivStartE = 1'b1; SpecialCaseE = 1'b1; #1;
        chk("sc_ifs", int'(ifs1), 1);
        chk("sc_bz", int'(bz1), 0);
        chk("sc_it", int'(it1), 0);
        tick();
        IDivStartE = 1'b0; SpecialCaseE = 1'b0; #1;
        chk("sc_dn", int'(dn1), 1);
        chk("sc_it1", int'(it1), 0);
        chk("sc_cnt", int'(cnt1), 0);
        tick();
        idle1("sc_end");
        // Early termination at 3rd BUSY cycle; EARLYTERM=0 instance runs all 10.
        FDivStartE = 1'b1; CyclesE = 6'd10;
        tick();
        FDivStartE = 1'b0;
        tick();
        tick();
        WZeroE = 1'b1; #1;
        chk("et_it3", int'(it1), 1);
        chk("et_cnt3", int'(cnt1), 8);
        tick();
        WZeroE = 1'b0; #1;
        chk("et1_dn", int'(dn1), 1);
        chk("et1_cnt", int'(cnt1), 0);
        for (int k = 4; k <= 10; k++) begin
            chk("et0_it", int'(it0), 1);
            chk("et0_cnt", int'(cnt0), 11 - k);
            chk("et0_dn", int'(dn0), 0);
            tick();
        end
        chk("et0_dn11", int'(dn0), 1);
        chk("et0_it11", int'(it0), 0);
        tick();
        idle1("et_end");
        // Flush in 2nd BUSY cycle, then immediate restart.
        FDivStartE = 1'b1; CyclesE = 6'd4;
        tick();
        FDivStartE = 1'b0;
        tick();
        FlushE = 1'b1; #1;
        chk("fl_it", int'(it1), 1);
        chk("fl_cnt", int'(cnt1), 3);
        tick();
        FlushE = 1'b0; #1;
        idle1("fl_idle");
        chk("fl_cnt0", int'(cnt1), 0);
        // Restart with CyclesE=2 and a 3-cycle stall in DONE.
        FDivStartE = 1'b1; CyclesE = 6'd2; #1;
        chk("rs_ifs", int'(ifs1), 1);
        tick();
        FDivStartE = 1'b0;
        chk("rs_cnt1", int'(cnt1), 2);
        tick();
        chk("rs_cnt2", int'(cnt1), 1);
        tick();
        StallM = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("st_dn", int'(dn1), 1);
            chk("st_bz", int'(bz1), 1);
            if (i < 2) tick();
        end
        StallM = 1'b0; #1;
        chk("st_acc_dn", int'(dn1), 1);
        chk("st_acc_bz", int'(bz1), 0);
        tick();
        idle1("st_end");
        // CyclesE=0 gives exactly one iteration.
        FDivStartE = 1'b1; CyclesE = 6'd0;
        tick();
        FDivStartE = 1'b0; #1;
        chk("c0_it", int'(it1), 1);
        chk("c0_cnt", int'(cnt1), 1);
        tick();
        chk("c0_dn", int'(dn1), 1);
        chk("c0_it2", int'(it1), 0);
        tick();
        // Asynchronous reset mid-BUSY.
        FDivStartE = 1'b1; CyclesE = 6'd6;
        tick();
        FDivStartE = 1'b0;
        tick();
        chk("ar_pre_it", int'(it1), 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_it", int'(it1), 0);
        chk("ar_bz", int'(bz1), 0);
        chk("ar_cnt", int'(cnt1), 0);
        chk("ar_dn", int'(dn1), 0);
        tick();
        tick();
        #3 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            idle1("ar_post");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fdivsqrt_seq_fsm.md
Name: fdivsqrt_seq_fsm

Overview:
- Sequencing controller for the radix-2/4 divide/square-root iteration datapath; owns the start/busy/done handshake between the Execute stage and the digit-recurrence loop.
- Loads a per-operation iteration count, steps the recurrence once per cycle, and terminates on the last step or on an exact early-termination result (WZeroE).
- Special cases, flushes and Memory-stage stalls are resolved here, so the datapath only sees qualified start and step enables.

Parameters:
CYCW, 6, width of the iteration counter and CyclesE; maximum iteration count is 2^CYCW-1.
EARLYTERM, 1, 1 = honour WZeroE early termination; 0 = ignore WZeroE.

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset; 0 forces reset state immediately
FDivStartE  input  1  FP divide/sqrt issued in Execute
IDivStartE  input  1  integer divide/remainder issued in Execute
SpecialCaseE  input  1  NaN/Inf/zero or integer B==0 / |A|<|B|; no iteration needed
CyclesE  input  CYCW  iteration count for this operation, valid with start
WZeroE  input  1  residual is exactly zero (from postprocessing)
FlushE  input  1  kill the operation in Execute
StallM  input  1  Memory stage stalled
IFDivStartE  output  1  one-cycle load pulse to the datapath: initialise the residual and the first quotient digit
IterEnE  output  1  advance the recurrence one step this cycle
FDivBusyE  output  1  stall request to the hazard unit
FDivDoneE  output  1  result ready, held until accepted
StepCntE  output  CYCW  iterations remaining

Behaviour:
- States: IDLE, BUSY, DONE. Reset (reset=0, asynchronous): state=IDLE, StepCntE=0. All outputs are 0 during reset.
- Start = (FDivStartE | IDivStartE) & ~FlushE. Both start inputs high together count as a single start.
- IDLE:
  - Start & SpecialCaseE -> DONE. IFDivStartE=1, no count load.
  - Start & ~SpecialCaseE -> BUSY. IFDivStartE=1. StepCntE loads max(CyclesE,1).
  - Otherwise stay in IDLE.
- BUSY:
  - IterEnE=1 every cycle in this state.
  - StepCntE decrements by 1 each cycle and saturates at 0.
  - StepCntE==1 -> DONE.
  - EARLYTERM & WZeroE -> DONE. StepCntE is forced to 0 on this exit.
  - FlushE -> IDLE. This has priority over both DONE exits. IterEnE is still 1 in the flush cycle. StepCntE is cleared.
- DONE:
  - FDivDoneE=1.
  - ~StallM -> IDLE; this is the acceptance cycle.
  - StallM -> hold DONE.
  - FlushE -> IDLE regardless of StallM.
- Outputs (combinational from state and inputs):
  - FDivBusyE = BUSY | (IDLE & Start & ~SpecialCaseE) | (DONE & StallM).
  - IterEnE = BUSY.
  - IFDivStartE = IDLE & Start.
  - FDivDoneE = DONE.
- Latency:
  - A start with CyclesE=N gives IFDivStartE in cycle 0, IterEnE in cycles 1..N, and FDivDoneE in cycle N+1.
  - A special case gives FDivDoneE in cycle 1.
- Starts arriving in BUSY or DONE are ignored; the hazard unit guarantees none while FDivBusyE=1.
- CyclesE is sampled only at IDLE->BUSY. Changes to it mid-operation have no effect.
- StepCntE is otherwise unchanged in IDLE and DONE.
- Reset asserted mid-operation aborts immediately to IDLE, with no done pulse after reset is released.

Test Plan:
- Reset, then FDivStartE=1, CyclesE=5 -> IFDivStartE in cycle 0; IterEnE in cycles 1-5; StepCntE 5,4,3,2,1; FDivDoneE in cycle 6; IDLE in cycle 7 with StallM=0.
- IDivStartE=1, SpecialCaseE=1 -> IFDivStartE=1, FDivBusyE=0, IterEnE never asserted, FDivDoneE=1 next cycle.
- CyclesE=10, WZeroE=1 at the 3rd BUSY cycle (EARLYTERM=1) -> DONE next cycle, StepCntE=0. Same stimulus with EARLYTERM=0 -> all 10 iterations run.
- CyclesE=4, FlushE=1 at the 2nd BUSY cycle -> IDLE next cycle; FDivDoneE never asserted; a new start is accepted in the following cycle.
- Operation reaches DONE with StallM=1 for 3 cycles -> FDivDoneE=1 and FDivBusyE=1 held for all 3 cycles; IDLE one cycle after StallM falls. Also: CyclesE=0 -> exactly 1 iteration.
- reset driven to 0 asynchronously (between clock edges) during BUSY -> outputs go to 0 without waiting for a clock edge; after release, state is IDLE with no done pulse.
